// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver.
//
// Contents:
//   br_code_e    - 3-bit branch condition codes carried on brchSig
//                  (control decode uses the same codes)
//   ctr_e        - 2-bit BHT saturating counter encodings
//   branch_taken - decodes a condition code against the ALU flags
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BCO  = 3'b001,
    BR_BEQZ = 3'b010,
    BR_BGEZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BNEZ = 3'b101,
    BR_BLEZ = 3'b110,
    BR_JMP  = 3'b111
  } br_code_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Actual branch direction. The overflow flag is reserved for future
  // signed compares and is deliberately not an input here.
  function automatic logic branch_taken(input logic [2:0] code,
                                        input logic       sf,
                                        input logic       zf,
                                        input logic       cf);
    logic t;
    t = 1'b0;
    case (code)
      BR_BEQZ: t = zf;
      BR_BNEZ: t = ~zf;
      BR_BLTZ: t = sf;
      BR_BGEZ: t = ~sf;
      BR_BLEZ: t = sf | zf;
      BR_BCO:  t = cf;
      BR_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_ctr2.sv
// sat_ctr2: next-state of a 2-bit saturating up/down counter.
// Purely combinational; the caller owns the storage.
//
// Ports:
//   ctr  in  2  current counter value
//   up   in  1  1 = count toward strongly taken, 0 = toward strongly not-taken
//   nxt  out 2  next counter value, clamped at 2'b00 / 2'b11
module sat_ctr2
  import branch_resolve_unit_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch resolver.
// Decodes the branch condition against the ALU flags, compares the actual
// direction with the fetch-time prediction and reports the outcome one cycle
// later. Owns the 2-bit-counter branch history table (read by fetch, trained
// here) and saturating branch / mispredict statistics.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   lkp_pc            fetch PC for prediction lookup
//   lkp_pred_taken    combinational prediction (MSB of the indexed counter)
//   res_valid         resolve request this cycle
//   res_pc            PC of the resolving branch
//   res_brchSig       branch condition code (br_code_e)
//   res_pred_taken    prediction that travelled down the pipe with the branch
//   sf, zf, of, cf    ALU flags of the branch compare (of reserved)
//   stall             hold: nothing accepted or updated, outputs hold
//   stat_clr          synchronous clear of both statistics counters
//   br_valid          a branch resolved on the last accepted cycle
//   br_taken          actual direction of that branch
//   br_mispredict     actual direction differed from the carried prediction
//   stat_branches     saturating resolved-branch count
//   stat_mispredicts  saturating mispredict count
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         IDX_W    = 4,
  parameter int         PC_W     = 16,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  lkp_pc,
  output logic             lkp_pred_taken,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [2:0]       res_brchSig,
  input  logic             res_pred_taken,
  input  logic             sf,
  input  logic             zf,
  input  logic             of,
  input  logic             cf,
  input  logic             stall,
  input  logic             stat_clr,
  output logic             br_valid,
  output logic             br_taken,
  output logic             br_mispredict,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int               ENTRIES = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] res_idx;
  logic             taken;
  logic             accept;
  logic             mispredict;
  logic             bht_update;
  logic [1:0]       bht_next;

  // Instructions are halfword aligned, so PC bit 0 never carries index
  // information; upper PC bits alias onto the same entries.
  assign lkp_idx = lkp_pc[IDX_W:1];
  assign res_idx = res_pc[IDX_W:1];

  // The lookup reads the stored value directly: a same-cycle update to the
  // same entry becomes visible only after the clock edge.
  assign lkp_pred_taken = bht[lkp_idx][1];

  assign taken      = branch_taken(res_brchSig, sf, zf, cf);
  assign accept     = res_valid & ~stall & (res_brchSig != BR_NONE);
  assign mispredict = taken ^ res_pred_taken;

  // Unconditional jumps carry no direction information, so they never
  // train the history table.
  assign bht_update = accept & (res_brchSig != BR_JMP);

  sat_ctr2 u_sat_ctr2 (
    .ctr (bht[res_idx]),
    .up  (taken),
    .nxt (bht_next)
  );

  // Bits that are intentionally ignored: the reserved overflow flag and the
  // PC bits outside the table index.
  logic unused_bits;
  assign unused_bits = ^{of, lkp_pc[0], lkp_pc[PC_W-1:IDX_W+1],
                         res_pc[0], res_pc[PC_W-1:IDX_W+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= INIT_CTR;
    end else if (bht_update) begin
      bht[res_idx] <= bht_next;
    end
  end

  // Result flops hold during a stall and drop to zero on an idle cycle, so
  // the redirect logic only ever sees a one-cycle pulse per branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_valid      <= 1'b0;
      br_taken      <= 1'b0;
      br_mispredict <= 1'b0;
    end else if (!stall) begin
      br_valid      <= accept;
      br_taken      <= accept & taken;
      br_mispredict <= accept & mispredict;
    end
  end

  // A clear takes priority over a same-cycle increment and is honoured even
  // while the pipe is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (stat_branches != CNT_MAX) stat_branches <= stat_branches + CNT_ONE;
      if (mispredict && (stat_mispredicts != CNT_MAX))
        stat_mispredicts <= stat_mispredicts + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (CNT_W = 4 so that counter
// saturation is reachable in a few cycles). A reference model of the result
// flops, statistics and history table predicts each cycle's outputs; the
// prediction is queued when stimulus is driven and popped after the edge.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lkp_pc;
  logic        lkp_pred_taken;
  logic        res_valid;
  logic [15:0] res_pc;
  logic [2:0]  res_brchSig;
  logic        res_pred_taken;
  logic        sf, zf, of, cf;
  logic        stall;
  logic        stat_clr;
  logic        br_valid;
  logic        br_taken;
  logic        br_mispredict;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  branch_resolve_unit #(
    .IDX_W(4), .PC_W(16), .CNT_W(4), .INIT_CTR(2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .lkp_pc           (lkp_pc),
    .lkp_pred_taken   (lkp_pred_taken),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_brchSig      (res_brchSig),
    .res_pred_taken   (res_pred_taken),
    .sf               (sf),
    .zf               (zf),
    .of               (of),
    .cf               (cf),
    .stall            (stall),
    .stat_clr         (stat_clr),
    .br_valid         (br_valid),
    .br_taken         (br_taken),
    .br_mispredict    (br_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       taken;
    logic       mis;
    logic [3:0] nbr;
    logic [3:0] nmis;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur;
  logic [1:0] m_bht [16];
  int         compared   = 0;
  int         mismatched = 0;

  function automatic logic m_taken(input logic [2:0] code, input logic s,
                                   input logic z, input logic c);
    logic t;
    case (code)
      3'b010:  t = z;
      3'b101:  t = ~z;
      3'b100:  t = s;
      3'b011:  t = ~s;
      3'b110:  t = s | z;
      3'b001:  t = c;
      3'b111:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    cur = '0;
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    sb_q.delete();
  endtask

  // Drive one cycle of resolve-side stimulus and queue the expected
  // post-edge outputs.
  task automatic drive(input logic v, input logic [15:0] pc, input logic [2:0] code,
                       input logic s, input logic z, input logic c, input logic pred,
                       input logic stl, input logic clr);
    logic acc, tk;
    int   idx;
    res_valid = v; res_pc = pc; res_brchSig = code;
    sf = s; zf = z; cf = c; of = 1'($urandom);
    res_pred_taken = pred; stall = stl; stat_clr = clr;
    tk  = m_taken(code, s, z, c);
    acc = v && !stl && (code != 3'b000);
    idx = int'(pc[4:1]);
    if (!stl) begin
      cur.valid = acc;
      cur.taken = acc & tk;
      cur.mis   = acc & (tk ^ pred);
    end
    if (clr) begin
      cur.nbr  = 4'd0;
      cur.nmis = 4'd0;
    end else if (acc) begin
      if (cur.nbr != 4'hF) cur.nbr = cur.nbr + 4'd1;
      if ((tk ^ pred) && cur.nmis != 4'hF) cur.nmis = cur.nmis + 4'd1;
    end
    if (acc && code != 3'b111) begin
      if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
      else if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
    end
    sb_q.push_back(cur);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic clr);
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, clr);
  endtask

  task automatic test_reset();
    exp_t e;
    e = '0;
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL reset_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
    for (int i = 0; i < 16; i++) begin
      lkp_pc = 16'(i * 2);
      #1;
      compared++;
      if (lkp_pred_taken !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_lkp[%0d]: got %b want 0", i, lkp_pred_taken);
      end
    end
  endtask

  task automatic test_training();
    exp_t e;
    logic exp_pred [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    lkp_pc = 16'h0006;
    #1;
    compared++;
    if (lkp_pred_taken !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL train_init: got %b want 0", lkp_pred_taken);
    end
    // three taken BEQZ then two not-taken BEQZ on entry 3
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h0006, 3'b010, 1'b0, (k < 3), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      compared++;
      if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
        mismatched++;
        $display("[TB] FAIL train_outs[%0d]: got %h want %h", k,
                 {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
      end
      compared++;
      if (lkp_pred_taken !== exp_pred[k]) begin
        mismatched++;
        $display("[TB] FAIL train_pred[%0d]: got %b want %b", k, lkp_pred_taken, exp_pred[k]);
      end
    end
  endtask

  task automatic test_decode();
    exp_t e;
    // code, sf, zf, cf, expected direction
    logic [6:0] vec [15] = '{
      {3'b010, 3'b010, 1'b1}, {3'b010, 3'b000, 1'b0},
      {3'b101, 3'b010, 1'b0}, {3'b101, 3'b000, 1'b1},
      {3'b100, 3'b100, 1'b1}, {3'b100, 3'b000, 1'b0},
      {3'b011, 3'b010, 1'b1}, {3'b011, 3'b100, 1'b0},
      {3'b110, 3'b010, 1'b1}, {3'b110, 3'b100, 1'b1},
      {3'b110, 3'b000, 1'b0}, {3'b001, 3'b001, 1'b1},
      {3'b001, 3'b110, 1'b0}, {3'b111, 3'b000, 1'b1},
      {3'b000, 3'b010, 1'b0}};
    drive_idle(1'b1);
    tick();
    e = sb_q.pop_front();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 16'h0002, vec[i][6:4], vec[i][3], vec[i][2], vec[i][1], 1'b0, 1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      compared++;
      if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
        mismatched++;
        $display("[TB] FAIL decode_outs[%0d]: got %h want %h", i,
                 {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
      end
      compared++;
      if ({br_valid, br_taken} !== {(vec[i][6:4] != 3'b000), vec[i][0]}) begin
        mismatched++;
        $display("[TB] FAIL decode_dir[%0d]: got %b%b want %b%b", i, br_valid, br_taken,
                 (vec[i][6:4] != 3'b000), vec[i][0]);
      end
    end
  endtask

  task automatic test_mispredict();
    exp_t e;
    drive_idle(1'b1);
    tick();
    e = sb_q.pop_front();
    drive(1'b1, 16'h0020, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== 11'b101_0001_0001) begin
      mismatched++;
      $display("[TB] FAIL mispredict_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, 11'b101_0001_0001);
    end
    drive(1'b1, 16'h0020, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL predict_ok_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
  endtask

  task automatic test_stall_collision();
    exp_t e;
    drive(1'b1, 16'h0002, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = sb_q.pop_front();
    lkp_pc = 16'h000A;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h000A, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      e = sb_q.pop_front();
      compared++;
      if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
        mismatched++;
        $display("[TB] FAIL stall_outs[%0d]: got %h want %h", k,
                 {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
      end
      compared++;
      if (lkp_pred_taken !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stall_bht[%0d]: got %b want 0", k, lkp_pred_taken);
      end
    end
    drive(1'b1, 16'h000A, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    compared++;
    if (lkp_pred_taken !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL collide_old: got %b want 0", lkp_pred_taken);
    end
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL collide_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
    compared++;
    if (lkp_pred_taken !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL collide_new: got %b want 1", lkp_pred_taken);
    end
    // stat_clr still clears while stalled; result flops hold
    drive(1'b1, 16'h000A, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL stall_clr_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
  endtask

  task automatic test_stats();
    exp_t e;
    drive_idle(1'b1);
    tick();
    e = sb_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(i * 2), 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      compared++;
      if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
        mismatched++;
        $display("[TB] FAIL stats_outs[%0d]: got %h want %h", i,
                 {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
      end
    end
    compared++;
    if ({stat_branches, stat_mispredicts} !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL stats_sat: got %h want ff", {stat_branches, stat_mispredicts});
    end
    drive(1'b1, 16'h0004, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== 11'b111_0000_0000) begin
      mismatched++;
      $display("[TB] FAIL stats_clr_wins: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, 11'b111_0000_0000);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    drive(1'b1, 16'h0002, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
    drive_idle(1'b0);
    e = sb_q.pop_front();
    lkp_pc = 16'h000A;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset_outs: got %h want 0",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts});
    end
    for (int i = 0; i < 16; i++) begin
      lkp_pc = 16'(i * 2);
      #1;
      compared++;
      if (lkp_pred_taken !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midrun_reset_lkp[%0d]: got %b want 0", i, lkp_pred_taken);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle(1'b0);
    tick();
    e = sb_q.pop_front();
    compared++;
    if ({br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts} !== e) begin
      mismatched++;
      $display("[TB] FAIL post_reset_outs: got %h want %h",
               {br_valid, br_taken, br_mispredict, stat_branches, stat_mispredicts}, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    lkp_pc = 16'h0000;
    model_reset();
    drive_idle(1'b0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset checks");
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    $display("[TB] training");
    test_training();
    $display("[TB] decode sweep");
    test_decode();
    $display("[TB] mispredict");
    test_mispredict();
    $display("[TB] stall and collision");
    test_stall_collision();
    $display("[TB] statistics");
    test_stats();
    $display("[TB] mid-run reset");
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
